mux2_rr_arbiter: RTL and testbench

//  Two-channel round-robin arbiter that drives the select of the 2:1 datapath mux and registers its output.

---
 rtl/mux2_rr_arbiter_pkg.sv | 17 +
 rtl/mux2_rr_arbiter_if.sv | 32 +++
 rtl/mux2_rr_arbiter_grant.sv | 33 +++
 rtl/mux2_rr_arbiter_mux2x1.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux2_rr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// rtl/mux2_rr_arbiter_pkg.sv - shared types and defaults for the two-channel round-robin arbiter
package mux2_rr_arbiter_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BEATS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  function automatic state_t lock_state(input logic ch);
    return ch ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// rtl/mux2_rr_arbiter_if.sv - two input channels, one output channel and status of the arbiter
interface mux2_rr_arbiter_if import mux2_rr_arbiter_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
);

  logic              in0_valid;
  logic              in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in0_last;
  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in1_last;
  logic              sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_src;
  logic              pkt_err;

  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, sel, out_valid, out_data, out_last, out_src, pkt_err
  );

  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, sel, out_valid, out_data, out_last, out_src, pkt_err
  );

endinterface

// File: rtl/mux2_rr_arbiter_grant.sv
// rtl/mux2_rr_arbiter_grant.sv - combinational grant/select from lock state, priority and valids
module rr_grant2 import mux2_rr_arbiter_pkg::*; (
  input  state_t state_i,
  input  logic   prio_i,
  input  logic   hold_i,
  input  logic   valid0_i,
  input  logic   valid1_i,
  output logic   grant_o,
  output logic   active_o
);

  always_comb begin
    grant_o  = hold_i;
    active_o = 1'b0;
    case (state_i)
      ST_LOCK0: begin
        grant_o  = 1'b0;
        active_o = 1'b1;
      end
      ST_LOCK1: begin
        grant_o  = 1'b1;
        active_o = 1'b1;
      end
      default: begin
        active_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) grant_o = prio_i;
        else if (valid0_i)        grant_o = 1'b0;
        else if (valid1_i)        grant_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mux2_rr_arbiter_mux2x1.sv
// rtl/mux2_rr_arbiter_mux2x1.sv - 1-bit 2:1 datapath mux cell
module mux2x1 (
  input  logic i0,
  input  logic i1,
  input  logic s0,
  output logic y
);

  assign y = s0 ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin packet arbiter driving a 2:1 mux into a registered output stage
module mux2_rr_arbiter import mux2_rr_arbiter_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic               clk,
  input  logic               rst_n,
  mux2_rr_arbiter_if.slave   bus
);

  localparam int              CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_src_q, out_src_d;
  logic              pkt_err_q, pkt_err_d;

  logic              grant, grant_active;
  logic              load_ok, ready0, ready1, accept;
  logic [DATA_W-1:0] mux_data;
  logic              mux_last;

  rr_grant2 u_grant (
    .state_i  (state_q),
    .prio_i   (prio_q),
    .hold_i   (sel_q),
    .valid0_i (bus.in0_valid),
    .valid1_i (bus.in1_valid),
    .grant_o  (grant),
    .active_o (grant_active)
  );

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux2x1 u_bit (.i0(bus.in0_data[i]), .i1(bus.in1_data[i]), .s0(grant), .y(mux_data[i]));
  end
  mux2x1 u_last (.i0(bus.in0_last), .i1(bus.in1_last), .s0(grant), .y(mux_last));

  // Readies are held low during reset even though the grant logic sees IDLE.
  always_comb begin
    load_ok = !out_valid_q || bus.out_ready;
    ready0  = rst_n && load_ok && grant_active && !grant;
    ready1  = rst_n && load_ok && grant_active && grant;
    accept  = (bus.in0_valid && ready0) || (bus.in1_valid && ready1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  // A packet that reaches MAX_BEATS without last is cut off and the other channel gets priority.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    sel_d      = grant;
    pkt_err_d  = 1'b0;
    if (accept) begin
      if (mux_last || beat_cnt_q == CNT_LAST) begin
        state_d    = ST_IDLE;
        prio_d     = ~grant;
        beat_cnt_d = '0;
        pkt_err_d  = !mux_last;
      end else begin
        state_d    = lock_state(grant);
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (load_ok) out_valid_d = accept;
    if (accept) begin
      out_data_d = mux_data;
      out_last_d = mux_last;
      out_src_d  = grant;
    end
  end

  assign bus.in0_ready = ready0;
  assign bus.in1_ready = ready1;
  assign bus.sel       = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed and randomized bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;

  localparam int MAXB = 4;

  typedef struct {
    int src;
    int data;
    int last;
    int err;
    int cyc;
  } beat_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   err_seen = 0;
  bit   acc0, acc1, en0, en1;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  beat_t      out_log[$];
  beat_t      exp_q[$];

  mux2_rr_arbiter_if #(.DATA_W(8)) bus ();

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BEATS(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int ch, input int data, input int last);
    logic [8:0] b;
    b = {last[0], data[7:0]};
    if (ch == 0) q0.push_back(b);
    else         q1.push_back(b);
  endtask

  task automatic expect_beat(input int src, input int data, input int last, input int err);
    beat_t b;
    b.src = src; b.data = data; b.last = last; b.err = err; b.cyc = 0;
    exp_q.push_back(b);
  endtask

  task automatic check_expect(input string name, input int base, input bit contiguous);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= out_log.size()) begin
        chk({name, "_missing"}, out_log.size(), base + i + 1);
      end else begin
        chk({name, "_data"}, out_log[base+i].data, exp_q[i].data);
        chk({name, "_src"},  out_log[base+i].src,  exp_q[i].src);
        chk({name, "_last"}, out_log[base+i].last, exp_q[i].last);
        chk({name, "_err"},  out_log[base+i].err,  exp_q[i].err);
        if (contiguous) chk({name, "_cyc"}, out_log[base+i].cyc - out_log[base].cyc, i);
      end
    end
    exp_q.delete();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      step();
      k++;
    end
    if (out_log.size() < n) chk("wait_log_timeout", out_log.size(), n);
  endtask

  // Source driver: each channel presents the head of its queue, popping it once accepted.
  always @(posedge clk) begin
    logic [8:0] tmp;
    #1;
    if (acc0 && q0.size() > 0) tmp = q0.pop_front();
    if (acc1 && q1.size() > 0) tmp = q1.pop_front();
    bus.in0_valid = (q0.size() > 0) && en0;
    bus.in1_valid = (q1.size() > 0) && en1;
    if (q0.size() > 0) {bus.in0_last, bus.in0_data} = q0[0];
    if (q1.size() > 0) {bus.in1_last, bus.in1_data} = q1[0];
  end

  // Reference model: owner of the current packet (-1 = none), preferred channel, beats taken,
  // and the beat the output register must be holding.
  int m_owner, m_prio, m_beats, m_sel, m_ov, m_od, m_ol, m_os, m_err;

  always @(negedge clk) begin
    int v0, v1, g, act, lok, er0, er1, acc, lst;
    cyc++;
    acc0 = bus.in0_valid && bus.in0_ready;
    acc1 = bus.in1_valid && bus.in1_ready;
    if (bus.out_valid && bus.out_ready)
      out_log.push_back('{int'(bus.out_src), int'(bus.out_data), int'(bus.out_last), int'(bus.pkt_err), cyc});
    if (bus.pkt_err) err_seen++;

    if (!rst_n) begin
      m_owner = -1; m_prio = 0; m_beats = 0; m_sel = 0;
      m_ov = 0; m_od = 0; m_ol = 0; m_os = 0; m_err = 0;
    end
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_data",  bus.out_data,  m_od);
    chk("out_last",  bus.out_last,  m_ol);
    chk("out_src",   bus.out_src,   m_os);
    chk("pkt_err",   bus.pkt_err,   m_err);

    v0 = bus.in0_valid;
    v1 = bus.in1_valid;
    act = 1;
    if (m_owner >= 0)    g = m_owner;
    else if (v0 && v1)   g = m_prio;
    else if (v0)         g = 0;
    else if (v1)         g = 1;
    else begin g = m_sel; act = 0; end
    lok = (m_ov == 0) || bus.out_ready;
    er0 = (rst_n && lok && act && g == 0) ? 1 : 0;
    er1 = (rst_n && lok && act && g == 1) ? 1 : 0;
    chk("sel",       bus.sel,       g);
    chk("in0_ready", bus.in0_ready, er0);
    chk("in1_ready", bus.in1_ready, er1);

    if (rst_n) begin
      acc = (g == 1) ? (v1 && er1) : (v0 && er0);
      m_sel = g;
      m_err = 0;
      if (lok) m_ov = acc;
      if (acc) begin
        m_od = (g == 1) ? int'(bus.in1_data) : int'(bus.in0_data);
        lst  = (g == 1) ? int'(bus.in1_last) : int'(bus.in0_last);
        m_ol = lst;
        m_os = g;
        if (lst != 0 || m_beats == MAXB - 1) begin
          m_owner = -1;
          m_prio  = 1 - g;
          m_beats = 0;
          m_err   = (lst == 0) ? 1 : 0;
        end else begin
          m_owner = g;
          m_beats = m_beats + 1;
        end
      end
    end
  end

  initial begin
    int base, k;
    logic [7:0] stall_d;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b0; bus.in0_data = '0; bus.in0_last = 1'b0;
    bus.in1_valid = 1'b0; bus.in1_data = '0; bus.in1_last = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;

    // Reset with both channels valid, then alternating single-beat packets.
    push(0, 8'hA0, 1); push(0, 8'hA1, 1);
    push(1, 8'hB0, 1); push(1, 8'hB1, 1);
    repeat (3) step();
    chk("rst_in0_ready", bus.in0_ready, 0);
    chk("rst_in1_ready", bus.in1_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    base = out_log.size();
    rst_n = 1'b1;
    #1;
    chk("first_sel",       bus.sel,       0);
    chk("first_in0_ready", bus.in0_ready, 1);
    chk("first_in1_ready", bus.in1_ready, 0);
    wait_log(base + 4, 40);
    expect_beat(0, 8'hA0, 1, 0); expect_beat(1, 8'hB0, 1, 0);
    expect_beat(0, 8'hA1, 1, 0); expect_beat(1, 8'hB1, 1, 0);
    check_expect("alt", base, 1'b1);

    // Three-beat packet on in0 while in1 waits.
    base = out_log.size();
    push(0, 8'hC0, 0); push(0, 8'hC1, 0); push(0, 8'hC2, 1);
    push(1, 8'hD0, 1); push(1, 8'hD1, 1);
    wait_log(base + 5, 40);
    expect_beat(0, 8'hC0, 0, 0); expect_beat(0, 8'hC1, 0, 0); expect_beat(0, 8'hC2, 1, 0);
    expect_beat(1, 8'hD0, 1, 0); expect_beat(1, 8'hD1, 1, 0);
    check_expect("lock", base, 1'b1);

    // Output stall in the middle of a packet.
    base = out_log.size();
    push(0, 8'hE0, 0); push(0, 8'hE1, 0); push(0, 8'hE2, 1);
    push(1, 8'hF0, 1);
    wait_log(base + 1, 40);
    bus.out_ready = 1'b0;
    stall_d = bus.out_data;
    chk("stall_valid", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_data",       bus.out_data,  stall_d);
      chk("stall_in0_ready",  bus.in0_ready, 0);
      chk("stall_in1_ready",  bus.in1_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    wait_log(base + 4, 40);
    expect_beat(0, 8'hE0, 0, 0); expect_beat(0, 8'hE1, 0, 0); expect_beat(0, 8'hE2, 1, 0);
    expect_beat(1, 8'hF0, 1, 0);
    check_expect("stall", base, 1'b0);

    // Runaway packet on in1 is cut after MAXB beats; the waiting in0 beat goes next.
    base = out_log.size();
    for (int i = 0; i < 6; i++) push(1, 8'h60 + i, 0);
    step(); step();
    push(0, 8'h70, 1);
    wait_log(base + 7, 60);
    expect_beat(1, 8'h60, 0, 0); expect_beat(1, 8'h61, 0, 0);
    expect_beat(1, 8'h62, 0, 0); expect_beat(1, 8'h63, 0, 1);
    expect_beat(0, 8'h70, 1, 0);
    expect_beat(1, 8'h64, 0, 0); expect_beat(1, 8'h65, 0, 0);
    check_expect("runaway", base, 1'b0);
    chk("err_pulses", err_seen, 1);

    // Reset while in1 holds the lock and a beat sits in the output register.
    bus.out_ready = 1'b0;
    push(1, 8'h80, 0); push(1, 8'h81, 1);
    push(0, 8'h90, 1);
    k = 0;
    while (!bus.out_valid && k < 20) begin step(); k++; end
    chk("lock_held_valid", bus.out_valid, 1);
    chk("lock_held_src",   bus.out_src,   1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_out_data",  bus.out_data,  0);
    chk("async_in1_ready", bus.in1_ready, 0);
    step(); step();
    base = out_log.size();
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_sel",       bus.sel,       0);
    chk("post_rst_in0_ready", bus.in0_ready, 1);
    wait_log(base + 2, 40);
    expect_beat(0, 8'h90, 1, 0); expect_beat(1, 8'h81, 1, 0);
    check_expect("post_rst", base, 1'b0);

    // Randomized traffic, backpressure and one mid-run reset, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 4) != 0);
      for (int ch = 0; ch < 2; ch++) begin
        if (((ch == 0) ? q0.size() : q1.size()) < 3 && $urandom_range(0, 3) == 0) begin
          k = $urandom_range(1, 6);
          for (int b = 0; b < k; b++) push(ch, $urandom_range(0, 255), (b == k - 1) ? 1 : 0);
        end
      end
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      step();
    end

    en0 = 1'b1;
    en1 = 1'b1;
    bus.out_ready = 1'b1;
    k = 0;
    while ((q0.size() + q1.size()) > 0 && k < 500) begin step(); k++; end
    chk("final_drain", q0.size() + q1.size(), 0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
